// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: async-FIFO write-side pointer, full/almost-full, level and sticky overflow
// Ports: clk_wr/rstn write clock and async active-low reset; wr_en producer request;
//   wq2_rptr synchronized Gray read pointer; ovf_clr clears wovf; wr_ok RAM write enable;
//   waddr RAM write address; wptr Gray write pointer; wfull/walmost_full/wlevel/wovf status.
module wptr_full_ctrl #(
  parameter int ADDSIZE  = 4,
  parameter int AFULL_TH = 12
) (
  input  logic               clk_wr,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [ADDSIZE:0]   wq2_rptr,
  input  logic               ovf_clr,
  output logic               wr_ok,
  output logic [ADDSIZE-1:0] waddr,
  output logic [ADDSIZE:0]   wptr,
  output logic               wfull,
  output logic               walmost_full,
  output logic [ADDSIZE:0]   wlevel,
  output logic               wovf
);
  localparam int PW = ADDSIZE + 1;
  logic [PW-1:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin;
  logic          wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wovf_d;
  assign wr_ok  = wr_en & ~wfull_q;
  assign wbin_d = wbin_q + PW'(wr_ok);
  assign wptr_d = (wbin_d >> 1) ^ wbin_d;
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) rbin = rbin ^ (wq2_rptr >> i);
  end
  // Full when the write pointer has lapped the read pointer by exactly one depth.
  assign wfull_d  = wptr_d == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
  assign wlevel_d = wbin_d - rbin;
  assign wafull_d = wlevel_d >= PW'(AFULL_TH);
  // A new overflow wins over a simultaneous clear.
  assign wovf_d   = (wr_en & wfull_q) | (wovf_q & ~ovf_clr);
  always_ff @(posedge clk_wr or negedge rstn) begin
    if (!rstn) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end
  assign waddr        = wbin_q[ADDSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed self-checking bench for wptr_full_ctrl
module tb_wptr_full_ctrl;
  logic       clk_wr = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic       ovf_clr = 1'b0;
  logic       wr_ok;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [4:0] prev_wptr = '0;
  logic       prev_ok = 1'b0;
  wptr_full_ctrl #(.ADDSIZE(4), .AFULL_TH(12)) dut (
    .clk_wr(clk_wr), .rstn(rstn), .wr_en(wr_en), .wq2_rptr(wq2_rptr), .ovf_clr(ovf_clr),
    .wr_ok(wr_ok), .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .wovf(wovf)
  );
  always #5 clk_wr = ~clk_wr;
  function automatic logic [4:0] gray(logic [4:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  always @(negedge clk_wr) begin
    if (rstn && prev_ok) chk("gray_step", 32'($countones(wptr ^ prev_wptr) <= 1), 1);
    prev_wptr = wptr;
    prev_ok   = rstn;
  end
  task automatic chk_regs(string tag, logic [4:0] p, logic f, logic af, logic [4:0] lv, logic o);
    chk({tag, "_wptr"}, wptr, p);
    chk({tag, "_wfull"}, wfull, f);
    chk({tag, "_afull"}, walmost_full, af);
    chk({tag, "_wlevel"}, wlevel, lv);
    chk({tag, "_wovf"}, wovf, o);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_wr);
      wr_en = i[0];
      #1;
      chk_regs("rst", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("rst_waddr", waddr, 0);
    end
    @(negedge clk_wr);
    wr_en = 1'b0;
    rstn  = 1'b1;
    repeat (2) @(negedge clk_wr);
    chk("idle_wptr", wptr, 0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #1;
      chk("fill_waddr", waddr, i);
      chk("fill_wr_ok", wr_ok, 1);
      @(negedge clk_wr);
      chk_regs("fill", gray(5'(i + 1)), i == 15, i >= 11, 5'(i + 1), 1'b0);
    end
    chk("fill_end_wptr", wptr, 5'b11000);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ovf_wr_ok", wr_ok, 0);
      @(negedge clk_wr);
      chk_regs("ovf", 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
    end
    ovf_clr = 1'b1;
    @(negedge clk_wr);
    chk("clr_with_ovf", wovf, 1);
    wr_en = 1'b0;
    @(negedge clk_wr);
    chk("clr_alone", wovf, 0);
    ovf_clr  = 1'b0;
    wq2_rptr = 5'b00001;
    #1;
    chk("drain_full_held", wfull, 1);
    @(negedge clk_wr);
    chk_regs("drain", 5'b11000, 1'b0, 1'b1, 5'd15, 1'b0);
    wr_en = 1'b1;
    #1;
    chk("drain_wr_ok", wr_ok, 1);
    chk("drain_waddr", waddr, 0);
    @(negedge clk_wr);
    chk_regs("refill", 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0);
    wq2_rptr = 5'b00011;
    #1;
    chk("rchg_wr_ok", wr_ok, 0);
    @(negedge clk_wr);
    chk_regs("rchg", 5'b11001, 1'b0, 1'b1, 5'd15, 1'b1);
    #1;
    chk("rchg2_wr_ok", wr_ok, 1);
    chk("rchg2_waddr", waddr, 1);
    @(negedge clk_wr);
    wr_en = 1'b0;
    chk_regs("rchg2", 5'b11011, 1'b1, 1'b1, 5'd16, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk_wr);
    ovf_clr = 1'b0;
    chk("ovf_cleared", wovf, 0);
    rstn = 1'b0;
    #1;
    chk_regs("rst2", 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk_wr);
    wq2_rptr = '0;
    rstn = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      wr_en    = 1'b1;
      wq2_rptr = gray(5'(k >= 3 ? k - 3 : 0));
      #1;
      chk("wrap_waddr", waddr, (k - 1) % 16);
      @(negedge clk_wr);
      chk("wrap_wptr", wptr, gray(5'(k)));
      chk("wrap_wfull", wfull, 0);
      chk("wrap_wlevel", wlevel, k < 3 ? k : 3);
      chk("wrap_le3", 32'(wlevel <= 5'd3), 1);
    end
    wr_en = 1'b0;
    chk("wrap_end_wptr", wptr, 0);
    @(negedge clk_wr);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
